// File: rtl/piezo_multi_sequencer.sv
// Multi-channel piezo pulse scheduler with wrap-safe absolute-time firing
// and a first-word-fall-through timestamp FIFO for external trigger edges.
//
// Channel FSM:
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | no schedule pending, output low
//   ST_ARMED | time/width loaded, waiting for registered due compare
//   ST_PULSE | output high, width down-counter running to 1
module piezo_multi_sequencer #(
   parameter int NUM_CH     = 4,
   parameter int TIME_W     = 32,
   parameter int WIDTH_W    = 16,
   parameter int FIFO_DEPTH = 8,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   input  logic [TIME_W-1:0]  time_now,
   input  logic               sched_valid,
   output logic               sched_ready,
   input  logic [CH_W-1:0]    sched_ch,
   input  logic [TIME_W-1:0]  sched_time,
   input  logic [WIDTH_W-1:0] sched_width,
   input  logic               piezo_enable_in,
   output logic [NUM_CH-1:0]  piezo_out,
   output logic [NUM_CH-1:0]  ch_armed,
   output logic [NUM_CH-1:0]  ch_busy,
   input  logic               event_trigger,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [TIME_W-1:0]  evt_time,
   output logic               evt_overflow,
   input  logic               evt_ovf_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PULSE} state_t;

   logic [NUM_CH-1:0] busy_vec;
   logic [NUM_CH-1:0] armed_vec;
   logic              sel_pulse;

   // A pulsing channel only accepts a cancel; other channels always accept.
   always_comb begin
      sel_pulse = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(sched_ch) == i) sel_pulse = busy_vec[i];
      end
      sched_ready = !reset_reset && (!sel_pulse || (sched_width == '0));
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t             state;
      logic [TIME_W-1:0]  fire_time;
      logic [WIDTH_W-1:0] cnt;
      logic [TIME_W-1:0]  diff;
      logic               due_q;
      logic               armed_q;
      logic               pulse_q;
      logic               hit;

      // Sign bit of the modular difference gives a wrap-safe "time reached".
      assign diff = time_now - fire_time;
      assign hit  = sched_valid && sched_ready && (int'(sched_ch) == i);

      // Channel sequencing: accept/cancel, registered due compare, width countdown.
      always_ff @(posedge clk_clk) begin
         if (reset_reset) begin
            state     <= ST_IDLE;
            fire_time <= '0;
            cnt       <= '0;
            due_q     <= 1'b0;
            armed_q   <= 1'b0;
            pulse_q   <= 1'b0;
         end else if (hit) begin
            due_q   <= 1'b0;
            pulse_q <= 1'b0;
            if (sched_width != '0) begin
               state     <= ST_ARMED;
               fire_time <= sched_time;
               cnt       <= sched_width;
               armed_q   <= 1'b1;
            end else begin
               state   <= ST_IDLE;
               armed_q <= 1'b0;
            end
         end else begin
            case (state)
               ST_ARMED: begin
                  due_q <= !diff[TIME_W-1];
                  if (due_q) begin
                     state   <= ST_PULSE;
                     due_q   <= 1'b0;
                     armed_q <= 1'b0;
                     pulse_q <= 1'b1;
                  end
               end
               ST_PULSE: begin
                  if (cnt == WIDTH_W'(1)) begin
                     state   <= ST_IDLE;
                     pulse_q <= 1'b0;
                  end else begin
                     cnt <= cnt - WIDTH_W'(1);
                  end
               end
               default: due_q <= 1'b0;
            endcase
         end
      end

      assign busy_vec[i]  = pulse_q;
      assign armed_vec[i] = armed_q;
   end

   assign ch_busy   = busy_vec;
   assign ch_armed  = armed_vec;
   // Gate sits after the register so a gated pulse is still consumed.
   assign piezo_out = busy_vec & {NUM_CH{piezo_enable_in}};

   logic sync1, sync2, sync3, rise_q;

   // Two-flop synchroniser, a history flop, and a registered rising-edge strobe.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync1  <= event_trigger;
         sync2  <= sync1;
         sync3  <= sync2;
         rise_q <= sync2 & ~sync3;
      end
   end

   logic [TIME_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              empty, full, pop, push_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = evt_ready && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
   assign push_ok = rise_q && (!full || pop) && !reset_reset;

   // Timestamp storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk_clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= time_now;
   end

   // Pointer bookkeeping and sticky overflow (a new drop beats a clear).
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         evt_overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
         if (rise_q && full && !pop) evt_overflow <= 1'b1;
         else if (evt_ovf_clr)       evt_overflow <= 1'b0;
      end
   end

   assign evt_valid = !empty;
   assign evt_time  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_piezo_multi_sequencer.sv
// Self-checking bench for piezo_multi_sequencer: pulse and event scoreboards.
module tb_piezo_multi_sequencer;

   localparam int NUM_CH     = 4;
   localparam int TIME_W     = 32;
   localparam int WIDTH_W    = 16;
   localparam int FIFO_DEPTH = 8;
   localparam int CH_W       = 2;

   logic               clk = 1'b0;
   logic               reset_reset;
   logic [TIME_W-1:0]  time_now;
   logic               sched_valid;
   logic               sched_ready;
   logic [CH_W-1:0]    sched_ch;
   logic [TIME_W-1:0]  sched_time;
   logic [WIDTH_W-1:0] sched_width;
   logic               piezo_enable_in;
   logic [NUM_CH-1:0]  piezo_out;
   logic [NUM_CH-1:0]  ch_armed;
   logic [NUM_CH-1:0]  ch_busy;
   logic               event_trigger;
   logic               evt_valid;
   logic               evt_ready;
   logic [TIME_W-1:0]  evt_time;
   logic               evt_overflow;
   logic               evt_ovf_clr;

   piezo_multi_sequencer #(
      .NUM_CH(NUM_CH), .TIME_W(TIME_W), .WIDTH_W(WIDTH_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk_clk(clk), .reset_reset(reset_reset), .time_now(time_now),
      .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_ch(sched_ch),
      .sched_time(sched_time), .sched_width(sched_width),
      .piezo_enable_in(piezo_enable_in), .piezo_out(piezo_out),
      .ch_armed(ch_armed), .ch_busy(ch_busy), .event_trigger(event_trigger),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_time(evt_time),
      .evt_overflow(evt_overflow), .evt_ovf_clr(evt_ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct {int ch; int cyc; int w;} fire_t;

   int                n_tests = 0;
   int                n_fail  = 0;
   int                cyc     = 0;
   fire_t             fire_q[$];
   logic [TIME_W-1:0] evt_q[$];
   logic [NUM_CH-1:0] prev_busy = '0;
   int                rise_cyc[NUM_CH];
   int                exp_w[NUM_CH];
   bit                skip_fall = 1'b0;

   task automatic fail_msg(input string name, input longint act, input longint req);
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
   endtask

   // Per-cycle monitor: gate relation and pulse start/length against the fire queue.
   task automatic sample();
      for (int i = 0; i < NUM_CH; i++) begin
         n_tests++;
         if (piezo_out[i] !== (ch_busy[i] & piezo_enable_in))
            fail_msg($sformatf("gate_ch%0d", i), longint'(piezo_out[i]), longint'(ch_busy[i] & piezo_enable_in));
         if (ch_busy[i] && !prev_busy[i]) begin
            fire_t e;
            n_tests++;
            if (fire_q.size() == 0) begin
               fail_msg($sformatf("unexpected_fire_ch%0d", i), cyc, -1);
               exp_w[i] = 0;
            end else begin
               e = fire_q.pop_front();
               if (e.ch !== i) fail_msg("fire_channel", i, e.ch);
               if (e.cyc !== cyc) fail_msg($sformatf("fire_cycle_ch%0d", i), cyc, e.cyc);
               exp_w[i] = e.w;
            end
            rise_cyc[i] = cyc;
         end
         if (!ch_busy[i] && prev_busy[i] && !skip_fall) begin
            n_tests++;
            if ((cyc - rise_cyc[i]) !== exp_w[i])
               fail_msg($sformatf("pulse_width_ch%0d", i), cyc - rise_cyc[i], exp_w[i]);
         end
      end
      prev_busy = ch_busy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      time_now = time_now + 1;
      sample();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Issue one schedule request; when a fire is expected, queue its start cycle.
   task automatic sched(input int ch, input logic [TIME_W-1:0] t, input int w, input bit expect_fire);
      int d;
      sched_valid = 1'b1;
      sched_ch    = CH_W'(ch);
      sched_time  = t;
      sched_width = WIDTH_W'(w);
      #1;
      n_tests++;
      if (sched_ready !== 1'b1) fail_msg("sched_ready_accept", longint'(sched_ready), 1);
      tick();
      sched_valid = 1'b0;
      if (w != 0) begin
         n_tests++;
         if (ch_armed[ch] !== 1'b1) fail_msg($sformatf("armed_after_sched_ch%0d", ch), longint'(ch_armed[ch]), 1);
         if (expect_fire) begin
            d = int'($signed(t - time_now));
            if (d < 0) d = 0;
            fire_q.push_back('{ch, cyc + 2 + d, w});
         end
      end
   endtask

   task automatic trigger_pulse(input bit expect_push);
      event_trigger = 1'b1;
      if (expect_push) evt_q.push_back(time_now + 3);
      tick();
      event_trigger = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset_reset = 1'b1;
      ticks(2);
      n_tests++; if (piezo_out !== '0)    fail_msg("reset_piezo_out", longint'(piezo_out), 0);
      n_tests++; if (ch_armed !== '0)     fail_msg("reset_ch_armed", longint'(ch_armed), 0);
      n_tests++; if (ch_busy !== '0)      fail_msg("reset_ch_busy", longint'(ch_busy), 0);
      n_tests++; if (evt_valid !== 1'b0)  fail_msg("reset_evt_valid", longint'(evt_valid), 0);
      n_tests++; if (evt_overflow !== 1'b0) fail_msg("reset_evt_overflow", longint'(evt_overflow), 0);
      n_tests++; if (sched_ready !== 1'b0) fail_msg("reset_sched_ready", longint'(sched_ready), 0);
      reset_reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_fire();
      time_now = 32'd100;
      tick();
      sched(0, 32'd120, 5, 1'b1);
      ticks(30);
      n_tests++; if (ch_armed[0] !== 1'b0 || ch_busy[0] !== 1'b0)
         fail_msg("basic_idle_after", longint'({ch_armed[0], ch_busy[0]}), 0);
   endtask

   task automatic test_wrap();
      time_now = 32'hFFFF_FFF0;
      tick();
      sched(1, 32'h0000_0004, 3, 1'b1);
      ticks(30);
      sched(1, time_now - 10, 2, 1'b1);
      ticks(6);
   endtask

   task automatic test_handshake_cancel();
      sched(2, time_now + 2, 10, 1'b1);
      for (int k = 0; k < 10 && !ch_busy[2]; k++) tick();
      n_tests++; if (ch_busy[2] !== 1'b1) fail_msg("ch2_busy_timeout", longint'(ch_busy[2]), 1);
      ticks(2);
      sched_valid = 1'b1; sched_ch = 2'd2; sched_time = time_now; sched_width = 16'd8;
      #1;
      n_tests++; if (sched_ready !== 1'b0) fail_msg("sched_ready_during_pulse", longint'(sched_ready), 0);
      tick();
      sched_valid = 1'b0;
      n_tests++; if (ch_busy[2] !== 1'b1) fail_msg("pulse_survives_refused", longint'(ch_busy[2]), 1);
      exp_w[2] = (cyc + 1) - rise_cyc[2];
      sched(2, 32'd0, 0, 1'b0);
      n_tests++; if (piezo_out[2] !== 1'b0 || ch_busy[2] !== 1'b0)
         fail_msg("cancel_drops_output", longint'({piezo_out[2], ch_busy[2]}), 0);
      sched(3, time_now + 20, 4, 1'b0);
      ticks(2);
      sched(3, time_now + 6, 2, 1'b1);
      ticks(30);
   endtask

   task automatic test_gate();
      piezo_enable_in = 1'b0;
      sched(0, time_now + 3, 4, 1'b1);
      ticks(12);
      piezo_enable_in = 1'b1;
      ticks(10);
   endtask

   task automatic test_back_to_back();
      logic [TIME_W-1:0] t;
      t = time_now + 8;
      sched(0, t, 3, 1'b1);
      sched(1, t, 5, 1'b1);
      ticks(16);
   endtask

   task automatic test_event_fifo();
      logic [TIME_W-1:0] stamp;
      int n;
      evt_ready = 1'b0;
      for (int k = 0; k < 10; k++) trigger_pulse(k < FIFO_DEPTH);
      ticks(3);
      n_tests++; if (evt_overflow !== 1'b1) fail_msg("overflow_set", longint'(evt_overflow), 1);
      n_tests++; if (evt_time !== evt_q[0]) fail_msg("fifo_head", longint'(evt_time), longint'(evt_q[0]));
      // Pop while full with a push landing on the same edge.
      event_trigger = 1'b1;
      stamp = time_now + 3;
      tick();
      event_trigger = 1'b0;
      ticks(2);
      evt_ready = 1'b1;
      n_tests++;
      if (evt_time !== evt_q[0]) fail_msg("pop_while_full_head", longint'(evt_time), longint'(evt_q[0]));
      void'(evt_q.pop_front());
      tick();
      evt_ready = 1'b0;
      evt_q.push_back(stamp);
      // Clear and new drop on the same edge: the drop wins.
      event_trigger = 1'b1;
      tick();
      event_trigger = 1'b0;
      ticks(2);
      evt_ovf_clr = 1'b1;
      tick();
      evt_ovf_clr = 1'b0;
      n_tests++; if (evt_overflow !== 1'b1) fail_msg("overflow_beats_clear", longint'(evt_overflow), 1);
      evt_ovf_clr = 1'b1;
      tick();
      evt_ovf_clr = 1'b0;
      n_tests++; if (evt_overflow !== 1'b0) fail_msg("overflow_clear", longint'(evt_overflow), 0);
      n = 0;
      evt_ready = 1'b1;
      for (int k = 0; k < 20 && evt_valid; k++) begin
         n_tests++;
         if (evt_q.size() == 0) fail_msg("fifo_extra_entry", longint'(evt_time), -1);
         else begin
            if (evt_time !== evt_q[0]) fail_msg("fifo_drain_stamp", longint'(evt_time), longint'(evt_q[0]));
            void'(evt_q.pop_front());
         end
         tick();
         n++;
      end
      evt_ready = 1'b0;
      n_tests++; if (n !== FIFO_DEPTH) fail_msg("fifo_count_after_full_pop", n, FIFO_DEPTH);
      n_tests++; if (evt_valid !== 1'b0) fail_msg("fifo_empty_after_drain", longint'(evt_valid), 0);
      // Empty FIFO: valid rises on the edge that performs the push.
      trigger_pulse(1'b1);
      tick();
      n_tests++; if (evt_valid !== 1'b0) fail_msg("evt_valid_early", longint'(evt_valid), 0);
      tick();
      n_tests++; if (evt_valid !== 1'b1) fail_msg("evt_valid_on_push", longint'(evt_valid), 1);
      n_tests++; if (evt_time !== evt_q[0]) fail_msg("evt_time_single", longint'(evt_time), longint'(evt_q[0]));
      void'(evt_q.pop_front());
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      n_tests++; if (evt_valid !== 1'b0) fail_msg("evt_valid_after_pop", longint'(evt_valid), 0);
   endtask

   task automatic test_reset_mid();
      sched(0, time_now + 2, 20, 1'b1);
      sched(1, time_now + 20, 5, 1'b0);
      for (int k = 0; k < 3; k++) trigger_pulse(1'b1);
      ticks(3);
      n_tests++; if (ch_busy[0] !== 1'b1) fail_msg("pre_reset_busy", longint'(ch_busy[0]), 1);
      n_tests++; if (evt_time !== evt_q[0]) fail_msg("pre_reset_head", longint'(evt_time), longint'(evt_q[0]));
      reset_reset = 1'b1;
      skip_fall = 1'b1;
      #1;
      n_tests++; if (sched_ready !== 1'b0) fail_msg("sched_ready_in_reset", longint'(sched_ready), 0);
      tick();
      n_tests++; if (piezo_out !== '0)      fail_msg("mid_reset_piezo_out", longint'(piezo_out), 0);
      n_tests++; if (ch_armed !== '0)       fail_msg("mid_reset_ch_armed", longint'(ch_armed), 0);
      n_tests++; if (ch_busy !== '0)        fail_msg("mid_reset_ch_busy", longint'(ch_busy), 0);
      n_tests++; if (evt_valid !== 1'b0)    fail_msg("mid_reset_evt_valid", longint'(evt_valid), 0);
      n_tests++; if (evt_overflow !== 1'b0) fail_msg("mid_reset_evt_overflow", longint'(evt_overflow), 0);
      reset_reset = 1'b0;
      skip_fall = 1'b0;
      evt_q.delete();
      ticks(30);
   endtask

   initial begin
      reset_reset = 1'b1; time_now = '0; sched_valid = 1'b0; sched_ch = '0;
      sched_time = '0; sched_width = '0; piezo_enable_in = 1'b1;
      event_trigger = 1'b0; evt_ready = 1'b0; evt_ovf_clr = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin rise_cyc[i] = 0; exp_w[i] = 0; end
      test_reset();
      test_basic_fire();
      test_wrap();
      test_handshake_cancel();
      test_gate();
      test_back_to_back();
      test_event_fifo();
      test_reset_mid();
      n_tests++;
      if (fire_q.size() != 0) fail_msg("fires_never_seen", fire_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/piezo_multi_sequencer.md
Name: piezo_multi_sequencer

Overview:
Parametrised successor to the single-channel piezo controller/RTC pairing. Provides NUM_CH independently scheduled piezo pulse channels, each firing at an absolute PTP/RTC time for a programmable pulse width. Also timestamps external trigger edges into a first-word-fall-through (FWFT) FIFO. Sits between the PTP/RTC time base and the piezo driver pins; software-facing logic drives the schedule handshake and drains the event FIFO.

Parameters:
NUM_CH, 4, number of piezo output channels (1..16)
TIME_W, 32, width of time base and scheduled times
WIDTH_W, 16, width of pulse-length field (clock cycles)
FIFO_DEPTH, 8, event timestamp FIFO depth (power of two, >=2)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous active-high reset
time_now  in  TIME_W  current PTP/RTC time, free-running, wraps
sched_valid  in  1  schedule request valid
sched_ready  out  1  schedule request accepted when high with sched_valid
sched_ch  in  clog2(NUM_CH) (min 1)  target channel
sched_time  in  TIME_W  absolute fire time
sched_width  in  WIDTH_W  pulse length in cycles; 0 = cancel
piezo_enable_in  in  1  global output gate
piezo_out  out  NUM_CH  pulse outputs
ch_armed  out  NUM_CH  channel in ARMED state
ch_busy  out  NUM_CH  channel in PULSE state
event_trigger  in  1  asynchronous external trigger
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  pop head when high with evt_valid
evt_time  out  TIME_W  FIFO head timestamp
evt_overflow  out  1  sticky: a trigger was dropped
evt_ovf_clr  in  1  clears evt_overflow

Behaviour:
- Reset (synchronous, active-high): all outputs 0 on the next edge; every channel IDLE; FIFO emptied; evt_overflow cleared; synchroniser flops cleared. Reset asserted mid-pulse drops piezo_out on that edge.
- Per-channel FSM states: IDLE, ARMED, PULSE.
- Schedule handshake: transfer occurs when sched_valid && sched_ready. sched_ready = !reset_reset && (state[sched_ch] != PULSE || sched_width == 0); combinational on sched_ch.
  - Width != 0: the channel loads time and width, then goes to ARMED. This overwrites any pending ARMED schedule.
  - Width == 0: the channel goes to IDLE immediately. Any ongoing pulse ends and piezo_out drops on the next edge.
  - sched_ch >= NUM_CH: accepted and ignored.
- Due test is wrap-safe: due = signed(time_now - stored_time) >= 0 over TIME_W bits. A time already past (less than 2^(TIME_W-1) behind) fires immediately.
- Pulse timing, ARMED: the due compare is registered. If due is seen at edge k, the state is PULSE and piezo_out is high from edge k+1 for exactly stored_width cycles, then IDLE.
- Minimum fire latency is 2 cycles after acceptance.
- piezo_enable_in low forces piezo_out to 0. FSM and counters run unchanged, so a gated pulse is consumed, not deferred. The gate is applied combinationally after the output register.
- Event capture:
  - event_trigger passes through a 2-flop synchroniser plus edge register.
  - A rising edge is detected 3 edges after the input rises; time_now on the detect cycle is pushed.
  - FIFO is FWFT: evt_valid = !empty, evt_time = head.
  - Full and no pop: the push is dropped and evt_overflow is set.
  - Full with a pop in the same cycle: the push is accepted.
  - Empty with push: evt_valid rises on the next edge.
  - evt_ovf_clr and a new overflow in the same cycle: overflow wins (stays 1).
- Channels are independent; simultaneous fires on several channels are allowed.

Test Plan:
- Basic fire: reset, time_now counts from 100. Schedule ch0 at time 120, width 5 -> ch_armed[0] high; piezo_out[0] high for exactly 5 cycles starting 1 cycle after time_now==120; ch_busy[0] matches; then IDLE.
- Wrap-around: time_now starts at 0xFFFF_FFF0, ch1 scheduled at 0x0000_0004, width 3 -> fires only after wrap (at 0x4), not at arm. Schedule at time_now-10 -> fires within 2 cycles of acceptance.
- Handshake and cancel: during ch2 PULSE, a width-8 request to ch2 -> sched_ready=0. Width-0 request to ch2 -> accepted and piezo_out[2] low next edge. Re-arm of ARMED ch3 with a new time -> only the new time fires.
- Gate: piezo_enable_in=0 across ch0's scheduled pulse -> piezo_out[0] stays 0, ch_busy[0] high for width cycles, no later fire after re-enable.
- Event FIFO: 10 trigger pulses with evt_ready=0 and FIFO_DEPTH=8 -> 8 entries with correct time_now+3 stamps in order; evt_overflow=1. Pop while full plus a simultaneous trigger -> count stays 8. evt_ovf_clr -> 0.
- Reset mid-operation: assert reset_reset during a pulse with 3 FIFO entries -> next edge piezo_out=0, ch_armed=0, evt_valid=0, evt_overflow=0.
